buffer_write_arbiter: RTL and testbench

// - Round-robin scheduler merging NUM_CH strobe-based sample sources into the single write port of the Buffer FIFO.
// - Per channel: one-entry holding register. Words are tagged {channel, sample}.
// - Drives Buffer data_in/data_in_valid and consumes data_in_ack.
// - Reports overruns (sample lost) and write-side stall (Buffer full, no ack).

---
 rtl/buffer_write_arbiter.sv | 117 +++++++++++
 tb/tb_buffer_write_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_write_arbiter.sv
// Round-robin merge of NUM_CH strobed sample sources into the Buffer write port.
// Each channel owns a one-entry holding register; lost samples are counted as overruns.
module buffer_write_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int CH_BITS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int SMP_W      = DATA_WIDTH - CH_BITS,
  parameter int STALL_MAX  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CH*SMP_W-1:0] smp_data,
  input  logic [NUM_CH-1:0]       smp_strobe,
  output logic [DATA_WIDTH-1:0]   buf_data,
  output logic                    buf_valid,
  input  logic                    buf_ack,
  output logic                    busy,
  output logic                    stall,
  output logic [NUM_CH-1:0]       ovr_flag,
  input  logic                    ovr_clr,
  output logic [15:0]             drop_cnt
);

  localparam int CNT_W = $clog2(STALL_MAX + 1);

  // Handshake: buf_valid rises with a grant and buf_data stays frozen until
  // buf_ack is sampled high; the word is then considered written.
  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  logic [NUM_CH-1:0]  pend;
  logic [SMP_W-1:0]   hold [NUM_CH];
  logic [CH_BITS-1:0] rr_ptr;
  logic [CNT_W-1:0]   send_cnt;

  logic               grant_ok;
  logic [CH_BITS-1:0] grant_idx;
  logic [CH_BITS-1:0] cand;
  logic [NUM_CH-1:0]  grant_vec;
  logic [NUM_CH-1:0]  cap_vec;
  logic [NUM_CH-1:0]  drop_vec;
  logic [15:0]        n_drop;
  logic [16:0]        drop_sum;

  // Walk from the farthest candidate back to rr_ptr+1 so the nearest pending channel wins.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = rr_ptr + CH_BITS'(k);
      if (pend[cand]) begin
        grant_ok  = 1'b1;
        grant_idx = cand;
      end
    end
    if (state != IDLE || !enable) grant_ok = 1'b0;
    grant_vec = '0;
    if (grant_ok) grant_vec[grant_idx] = 1'b1;
  end

  // A grant frees the slot in the same cycle, so a coincident strobe is stored, not dropped.
  always_comb begin
    cap_vec  = enable ? (smp_strobe & (~pend | grant_vec)) : '0;
    drop_vec = enable ? (smp_strobe & pend & ~grant_vec) : '0;
    n_drop   = '0;
    for (int i = 0; i < NUM_CH; i++) n_drop = n_drop + 16'(drop_vec[i]);
    drop_sum = {1'b0, (ovr_clr ? 16'h0 : drop_cnt)} + {1'b0, n_drop};
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (cap_vec[i]) hold[i] <= smp_data[i*SMP_W +: SMP_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pend      <= '0;
      rr_ptr    <= CH_BITS'(NUM_CH - 1);
      send_cnt  <= '0;
      buf_data  <= '0;
      buf_valid <= 1'b0;
      ovr_flag  <= '0;
      drop_cnt  <= '0;
    end else begin
      pend     <= (pend & ~grant_vec) | cap_vec;
      ovr_flag <= (ovr_clr ? '0 : ovr_flag) | drop_vec;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      case (state)
        IDLE: begin
          if (grant_ok) begin
            buf_data  <= {grant_idx, hold[grant_idx]};
            buf_valid <= 1'b1;
            rr_ptr    <= grant_idx;
            send_cnt  <= CNT_W'(1);
            state     <= SEND;
          end
        end
        SEND: begin
          if (buf_ack) begin
            buf_valid <= 1'b0;
            state     <= IDLE;
          end else if (send_cnt < CNT_W'(STALL_MAX)) begin
            send_cnt <= send_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == SEND);
  assign stall = (state == SEND) && (send_cnt >= CNT_W'(STALL_MAX));

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Directed bench for buffer_write_arbiter: expected words are queued as samples
// are issued, and a monitor pops them at each Buffer write.
module tb_buffer_write_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [119:0] smp_data;
  logic [3:0]   smp_strobe;
  logic [31:0]  buf_data;
  logic         buf_valid;
  logic         buf_ack;
  logic         busy;
  logic         stall;
  logic [3:0]   ovr_flag;
  logic         ovr_clr;
  logic [15:0]  drop_cnt;

  logic [31:0] exp_q[$];
  int          xfer_cyc[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        auto_ack = 1'b0;
  logic        manual_ack = 1'b0;
  int          base;

  buffer_write_arbiter dut (
    .clk(clk), .rst(rst), .enable(enable), .smp_data(smp_data), .smp_strobe(smp_strobe),
    .buf_data(buf_data), .buf_valid(buf_valid), .buf_ack(buf_ack), .busy(busy),
    .stall(stall), .ovr_flag(ovr_flag), .ovr_clr(ovr_clr), .drop_cnt(drop_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_smp(input int ch, input logic [29:0] val);
    smp_data[ch*30 +: 30] = val;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    smp_strobe = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Buffer model: registered one-cycle ack in auto mode, otherwise driven by the test
  initial begin : buffer_model
    logic v;
    buf_ack = 1'b0;
    forever begin
      @(negedge clk);
      v = buf_valid;
      @(posedge clk);
      #2;
      if (auto_ack) buf_ack = v && !buf_ack;
      else          buf_ack = manual_ack;
    end
  end

  // scoreboard monitor
  initial begin : monitor
    logic [31:0] exp_w;
    forever begin
      @(negedge clk);
      if (rst && buf_valid && buf_ack) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", buf_data, 32'hxxxx_xxxx);
        end else begin
          exp_w = exp_q.pop_front();
          chk("write_word", buf_data, exp_w);
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b0; enable = 1'b0; smp_data = '0; smp_strobe = '0; ovr_clr = 1'b0;
    #2;
    chk("rst_buf_data", buf_data, 32'h0);
    chk("rst_buf_valid", {31'b0, buf_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_ovr_flag", {28'b0, ovr_flag}, 32'h0);
    chk("rst_drop_cnt", {16'b0, drop_cnt}, 32'h0);
    step();
    step();
    rst = 1'b1;
    enable = 1'b1;

    // single word on ch2, ack held off
    step();
    set_smp(2, 30'h1234); smp_strobe = 4'b0100; exp_q.push_back(32'h8000_1234);
    step();
    smp_strobe = '0;
    @(negedge clk);
    chk("single_not_yet", {31'b0, buf_valid}, 32'h0);
    step();
    @(negedge clk);
    chk("single_valid", {31'b0, buf_valid}, 32'h1);
    chk("single_data", buf_data, 32'h8000_1234);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("single_hold_valid", {31'b0, buf_valid}, 32'h1);
      chk("single_hold_data", buf_data, 32'h8000_1234);
    end
    step();
    manual_ack = 1'b1;
    step();
    manual_ack = 1'b0;
    @(negedge clk);
    chk("single_valid_drop", {31'b0, buf_valid}, 32'h0);
    chk("single_busy_drop", {31'b0, busy}, 32'h0);

    // round robin from reset, Buffer acking promptly
    do_reset();
    auto_ack = 1'b1;
    base = xfer_cyc.size();
    step();
    set_smp(0, 30'h101); set_smp(1, 30'h202); set_smp(2, 30'h303); set_smp(3, 30'h404);
    smp_strobe = 4'b1111;
    exp_q.push_back(32'h0000_0101); exp_q.push_back(32'h4000_0202);
    exp_q.push_back(32'h8000_0303); exp_q.push_back(32'hC000_0404);
    step();
    smp_strobe = '0;
    repeat (16) step();
    chk("rr_xfers", xfer_cyc.size() - base, 32'd4);
    if (xfer_cyc.size() >= base + 4)
      for (int i = 1; i < 4; i++)
        chk("rr_spacing", xfer_cyc[base+i] - xfer_cyc[base+i-1], 32'd3);
    set_smp(1, 30'h0ABC); set_smp(3, 30'h0DEF); smp_strobe = 4'b1010;
    exp_q.push_back(32'h4000_0ABC); exp_q.push_back(32'hC000_0DEF);
    step();
    smp_strobe = '0;
    repeat (10) step();

    // overrun on ch1 while ch0 waits for ack
    auto_ack = 1'b0;
    set_smp(0, 30'h1111); smp_strobe = 4'b0001; exp_q.push_back(32'h0000_1111);
    step();
    smp_strobe = '0;
    step();
    set_smp(1, 30'h2221); smp_strobe = 4'b0010; exp_q.push_back(32'h4000_2221);
    step();
    set_smp(1, 30'h2222);
    step();
    set_smp(1, 30'h2223);
    step();
    smp_strobe = '0;
    @(negedge clk);
    chk("ovr_flag", {28'b0, ovr_flag}, 32'h2);
    chk("ovr_drop_cnt", {16'b0, drop_cnt}, 32'd2);
    step();
    manual_ack = 1'b1;
    step();
    manual_ack = 1'b0;
    auto_ack = 1'b1;
    repeat (8) step();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    @(negedge clk);
    chk("clr_ovr_flag", {28'b0, ovr_flag}, 32'h0);
    chk("clr_drop_cnt", {16'b0, drop_cnt}, 32'h0);

    // stall after STALL_MAX SEND cycles; drop coincident with ovr_clr
    auto_ack = 1'b0;
    step();
    set_smp(3, 30'h3333); smp_strobe = 4'b1000; exp_q.push_back(32'hC000_3333);
    step();
    smp_strobe = '0;
    step();
    @(negedge clk);
    chk("stall_busy", {31'b0, busy}, 32'h1);
    chk("stall_early", {31'b0, stall}, 32'h0);
    repeat (14) step();
    @(negedge clk);
    chk("stall_cycle15", {31'b0, stall}, 32'h0);
    step();
    @(negedge clk);
    chk("stall_cycle16", {31'b0, stall}, 32'h1);
    step();
    set_smp(2, 30'h5555); smp_strobe = 4'b0100; exp_q.push_back(32'h8000_5555);
    step();
    set_smp(2, 30'h5556); ovr_clr = 1'b1;
    step();
    smp_strobe = '0; ovr_clr = 1'b0;
    @(negedge clk);
    chk("clr_vs_drop_flag", {28'b0, ovr_flag}, 32'h4);
    chk("clr_vs_drop_cnt", {16'b0, drop_cnt}, 32'd1);
    step();
    manual_ack = 1'b1;
    @(negedge clk);
    chk("stall_saturated", {31'b0, stall}, 32'h1);
    step();
    manual_ack = 1'b0;
    @(negedge clk);
    chk("stall_cleared", {31'b0, stall}, 32'h0);
    auto_ack = 1'b1;
    repeat (8) step();

    // enable low: strobes ignored
    enable = 1'b0;
    set_smp(0, 30'h7777); smp_strobe = 4'b0001;
    step();
    smp_strobe = '0;
    step();
    smp_strobe = 4'b0001;
    step();
    smp_strobe = '0;
    repeat (3) step();
    @(negedge clk);
    chk("en_no_valid", {31'b0, buf_valid}, 32'h0);
    chk("en_no_busy", {31'b0, busy}, 32'h0);
    chk("en_drop_cnt", {16'b0, drop_cnt}, 32'd1);

    // enable dropped mid-SEND: word still completes
    auto_ack = 1'b0;
    enable = 1'b1;
    set_smp(1, 30'h6666); smp_strobe = 4'b0010; exp_q.push_back(32'h4000_6666);
    step();
    smp_strobe = '0;
    step();
    enable = 1'b0;
    @(negedge clk);
    chk("en_send_busy", {31'b0, busy}, 32'h1);
    step();
    manual_ack = 1'b1;
    step();
    manual_ack = 1'b0;
    @(negedge clk);
    chk("en_send_done", {31'b0, buf_valid}, 32'h0);

    // asynchronous reset mid-SEND abandons the word
    enable = 1'b1;
    step();
    set_smp(0, 30'h1); smp_strobe = 4'b0001;
    step();
    smp_strobe = '0;
    step();
    @(negedge clk);
    chk("arst_pre_busy", {31'b0, busy}, 32'h1);
    step();
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'b0, buf_valid}, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_drop_cnt", {16'b0, drop_cnt}, 32'h0);
    step();
    rst = 1'b1;
    auto_ack = 1'b1;
    repeat (10) step();
    @(negedge clk);
    chk("arst_no_pend", {31'b0, buf_valid}, 32'h0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
